// File: rtl/lh_pkg.sv
// Shared types and helper functions for the iterative light hash.
package lh_pkg;

  // Controller states: waiting for a byte, mixing it, presenting the digest.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } lh_state_t;

  // AES forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] AES_SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // S-box lookup.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    int idx;
    idx = 255 - int'(x);
    return AES_SBOX_TABLE[idx*8 +: 8];
  endfunction

  // Rotate a byte left by 0..7 positions.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] amt);
    logic [15:0] w;
    w = {x, x} << amt;
    return w[15:8];
  endfunction

  // Initial value of state byte i.
  function automatic logic [7:0] lh_iv(input int unsigned i);
    logic [7:0] lo;
    lo = i[7:0];
    return 8'h5A ^ lo;
  endfunction

  // True for ASCII digits and letters.
  function automatic logic is_alnum(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h5A)) ||
           ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/lh_round.sv
// One full mixing round: every state byte updated once, in index order.
module lh_round
  import lh_pkg::*;
#(
  parameter int DIGEST_BYTES = 8
) (
  input  logic [8*DIGEST_BYTES-1:0] state_in,
  input  logic [7:0]                char_in,
  output logic [8*DIGEST_BYTES-1:0] state_out
);

  logic [8*DIGEST_BYTES-1:0] work;

  // Sequential in-place update: later bytes see bytes already rewritten this round.
  always_comb begin
    work = state_in;
    for (int i = 0; i < DIGEST_BYTES; i++) begin
      work[i*8 +: 8] = aes_sbox(rotl8(work[((i + 2) % DIGEST_BYTES)*8 +: 8] ^ char_in,
                                      3'(i % 8)));
    end
    state_out = work;
  end

endmodule

// File: rtl/light_hash_iter.sv
// Byte-serial iterative light hash with ready/valid input and ready/ack digest.
module light_hash_iter
  import lh_pkg::*;
#(
  parameter int DIGEST_BYTES  = 8,
  parameter int ROUNDS        = 32,
  parameter bit CHARSET_CHECK = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                ptxt_char,
  input  logic                      ptxt_valid,
  input  logic                      ptxt_last,
  output logic                      ptxt_ready,
  output logic [8*DIGEST_BYTES-1:0] digest_char,
  output logic                      digest_ready,
  input  logic                      digest_ack,
  output logic                      err_invalid_ptxt_char
);

  localparam int CNT_W = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - 1);

  lh_state_t fsm_reg, fsm_next;

  logic [8*DIGEST_BYTES-1:0] d_reg;
  logic [8*DIGEST_BYTES-1:0] iv_vec;
  logic [8*DIGEST_BYTES-1:0] round_out;
  logic [8*DIGEST_BYTES-1:0] digest_reg;
  logic [7:0]                char_reg;
  logic                      last_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic                      err_reg;
  logic                      digest_ready_reg;
  logic                      ptxt_ready_reg;

  logic take_byte;
  logic byte_bad;
  logic do_round;
  logic round_end;
  logic take_ack;

  // Initial value vector, one byte per state position.
  for (genvar gi = 0; gi < DIGEST_BYTES; gi++) begin : g_iv
    assign iv_vec[gi*8 +: 8] = lh_iv(gi);
  end

  lh_round #(
    .DIGEST_BYTES(DIGEST_BYTES)
  ) u_round (
    .state_in (d_reg),
    .char_in  (char_reg),
    .state_out(round_out)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_reg <= IDLE;
    else        fsm_reg <= fsm_next;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    fsm_next  = fsm_reg;
    take_byte = 1'b0;
    byte_bad  = 1'b0;
    do_round  = 1'b0;
    round_end = 1'b0;
    take_ack  = 1'b0;
    case (fsm_reg)
      IDLE: begin
        if (ptxt_valid && ptxt_ready_reg) begin
          take_byte = 1'b1;
          if (CHARSET_CHECK && !is_alnum(ptxt_char)) begin
            // Rejected bytes are never mixed; only the last one ends the message.
            byte_bad = 1'b1;
            if (ptxt_last) fsm_next = DONE;
          end else begin
            fsm_next = ROUND;
          end
        end
      end
      ROUND: begin
        do_round = 1'b1;
        if (cnt_reg == LAST_CNT) begin
          round_end = 1'b1;
          fsm_next  = last_reg ? DONE : IDLE;
        end
      end
      DONE: begin
        if (digest_ack) begin
          take_ack = 1'b1;
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Hash state, latched byte and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg    <= iv_vec;
      char_reg <= 8'h00;
      last_reg <= 1'b0;
      cnt_reg  <= '0;
    end else begin
      if (take_byte) begin
        char_reg <= ptxt_char;
        last_reg <= ptxt_last;
        cnt_reg  <= '0;
      end
      if (do_round) begin
        d_reg   <= round_out;
        cnt_reg <= round_end ? '0 : cnt_reg + 1'b1;
      end
      if (take_ack) d_reg <= iv_vec;
    end
  end

  // Handshake outputs, sticky error flag and registered digest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptxt_ready_reg   <= 1'b0;
      digest_ready_reg <= 1'b0;
      digest_reg       <= '0;
      err_reg          <= 1'b0;
    end else begin
      ptxt_ready_reg <= (fsm_next == IDLE);
      if (take_ack) begin
        digest_ready_reg <= 1'b0;
        digest_reg       <= '0;
        err_reg          <= 1'b0;
      end else begin
        if (byte_bad) err_reg <= 1'b1;
        if ((fsm_next == DONE) && (fsm_reg != DONE)) begin
          // A message with any rejected byte yields an all-zero digest.
          digest_ready_reg <= 1'b1;
          digest_reg       <= (err_reg || byte_bad) ? '0 : round_out;
        end
      end
    end
  end

  assign ptxt_ready            = ptxt_ready_reg;
  assign digest_ready          = digest_ready_reg;
  assign digest_char           = digest_reg;
  assign err_invalid_ptxt_char = err_reg;

endmodule

// File: tb/tb_light_hash_iter.sv
// Scoreboard bench for light_hash_iter: three instances cover the default
// configuration, the unchecked charset and the smallest legal size.
module tb_light_hash_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  pc [3];
  logic        pv [3];
  logic        pl [3];
  logic        ack[3];
  logic        pr [3];
  logic        dr [3];
  logic        er [3];
  logic [63:0] dg0, dg1;
  logic [23:0] dg2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] dig;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [63:0] cur_dig [3];
  logic        cur_err [3];
  logic        cur_ok  [3];
  logic        dr_prev [3];
  logic [7:0]  sbox_tb [256];

  light_hash_iter #(.DIGEST_BYTES(8), .ROUNDS(32), .CHARSET_CHECK(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .ptxt_char(pc[0]), .ptxt_valid(pv[0]), .ptxt_last(pl[0]),
    .ptxt_ready(pr[0]), .digest_char(dg0), .digest_ready(dr[0]), .digest_ack(ack[0]),
    .err_invalid_ptxt_char(er[0]));

  light_hash_iter #(.DIGEST_BYTES(8), .ROUNDS(32), .CHARSET_CHECK(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ptxt_char(pc[1]), .ptxt_valid(pv[1]), .ptxt_last(pl[1]),
    .ptxt_ready(pr[1]), .digest_char(dg1), .digest_ready(dr[1]), .digest_ack(ack[1]),
    .err_invalid_ptxt_char(er[1]));

  light_hash_iter #(.DIGEST_BYTES(3), .ROUNDS(1), .CHARSET_CHECK(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ptxt_char(pc[2]), .ptxt_valid(pv[2]), .ptxt_last(pl[2]),
    .ptxt_ready(pr[2]), .digest_char(dg2), .digest_ready(dr[2]), .digest_ack(ack[2]),
    .err_invalid_ptxt_char(er[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rot8(input logic [7:0] v_in, input int s);
    logic [7:0] v;
    v = v_in;
    for (int j = 0; j < s; j++) v = {v[6:0], v[7]};
    return v;
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rot8(inv, 1) ^ rot8(inv, 2) ^ rot8(inv, 3) ^ rot8(inv, 4) ^ 8'h63;
      sbox_tb[x] = s;
    end
  endtask

  function automatic logic alnum_tb(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic void model_hash(input string s, input int n, input int r, input bit chk,
                                     output logic [63:0] dig, output logic e);
    logic [7:0] d[8];
    logic [7:0] c, t;
    for (int i = 0; i < 8; i++) d[i] = 8'h5A ^ 8'(i);
    e = 1'b0;
    for (int m = 0; m < s.len(); m++) begin
      c = s[m];
      if (chk && !alnum_tb(c)) begin
        e = 1'b1;
      end else begin
        for (int rr = 0; rr < r; rr++)
          for (int i = 0; i < n; i++) begin
            t = d[(i + 2) % n] ^ c;
            t = rot8(t, i % 8);
            d[i] = sbox_tb[t];
          end
      end
    end
    dig = 64'h0;
    if (!e) for (int i = 0; i < n; i++) dig[i*8 +: 8] = d[i];
  endfunction

  function automatic int n_of(input int k);   return (k == 2) ? 3 : 8;  endfunction
  function automatic int r_of(input int k);   return (k == 2) ? 1 : 32; endfunction
  function automatic bit chk_of(input int k); return (k != 1);          endfunction

  function automatic logic [63:0] dgw(input int k);
    case (k)
      0:       return dg0;
      1:       return dg1;
      default: return {40'h0, dg2};
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input string s);
    exp_t e;
    model_hash(s, n_of(k), r_of(k), chk_of(k), e.dig, e.err);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop_exp(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // Monitor: a new digest is a rising digest_ready; it is checked every cycle it is held.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (dr[k] === 1'b1 && dr_prev[k] !== 1'b1) begin
        if (qsize(k) == 0) begin
          total++;
          bad++;
          cur_ok[k] = 1'b0;
          $display("FAIL unexpected_digest dut%0d: got %h expected none", k, dgw(k));
        end else begin
          pop_exp(k, e);
          cur_dig[k] = e.dig;
          cur_err[k] = e.err;
          cur_ok[k]  = 1'b1;
          $display("dut%0d digest %h err %b (expected %h err %b)", k, dgw(k), er[k], e.dig, e.err);
        end
      end
      if (dr[k] === 1'b1 && cur_ok[k]) begin
        chk($sformatf("digest_dut%0d", k), dgw(k), cur_dig[k]);
        chk($sformatf("err_in_done_dut%0d", k), {63'h0, er[k]}, {63'h0, cur_err[k]});
      end
      dr_prev[k] = dr[k];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input int k, input logic [7:0] ch, input logic last);
    int n;
    n = 0;
    pc[k] = ch; pl[k] = last; pv[k] = 1'b1;
    while (pr[k] !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (pr[k] !== 1'b1) chk($sformatf("accept_timeout_dut%0d", k), 64'(pr[k]), 64'h1);
    @(posedge clk); #1;
    pv[k] = 1'b0; pl[k] = 1'b0;
  endtask

  task automatic send_str(input int k, input string s);
    for (int i = 0; i < s.len(); i++) send_byte(k, s[i], (i == s.len() - 1));
  endtask

  task automatic wait_dr(input int k, output int n);
    n = 0;
    while (dr[k] !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (dr[k] !== 1'b1) chk($sformatf("digest_timeout_dut%0d", k), 64'(dr[k]), 64'h1);
  endtask

  task automatic wait_pr(input int k, output int n);
    n = 0;
    while (pr[k] !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (pr[k] !== 1'b1) chk($sformatf("ready_timeout_dut%0d", k), 64'(pr[k]), 64'h1);
  endtask

  task automatic do_ack(input int k);
    repeat (10) @(posedge clk);
    #1;
    chk($sformatf("digest_held_dut%0d", k), 64'(dr[k]), 64'h1);
    ack[k] = 1'b1;
    @(posedge clk); #1;
    ack[k] = 1'b0;
    chk($sformatf("ready_drop_after_ack_dut%0d", k), 64'(dr[k]), 64'h0);
    chk($sformatf("ptxt_ready_after_ack_dut%0d", k), 64'(pr[k]), 64'h1);
    chk($sformatf("err_clear_after_ack_dut%0d", k), 64'(er[k]), 64'h0);
  endtask

  task automatic chk_outputs_zero(input int k, input string tag);
    chk($sformatf("%s_ptxt_ready_dut%0d", tag, k), 64'(pr[k]), 64'h0);
    chk($sformatf("%s_digest_ready_dut%0d", tag, k), 64'(dr[k]), 64'h0);
    chk($sformatf("%s_err_dut%0d", tag, k), 64'(er[k]), 64'h0);
    chk($sformatf("%s_digest_dut%0d", tag, k), dgw(k), 64'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    build_sbox();
    for (int k = 0; k < 3; k++) begin
      pc[k] = 8'h00; pv[k] = 1'b0; pl[k] = 1'b0; ack[k] = 1'b0;
      dr_prev[k] = 1'b0; cur_ok[k] = 1'b0; cur_dig[k] = 64'h0; cur_err[k] = 1'b0;
    end

    // Reset and release.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_outputs_zero(k, "reset");
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("ready_at_release_dut%0d", k), 64'(pr[k]), 64'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_release_dut%0d", k), 64'(pr[k]), 64'h1);

    // Quiet period.
    repeat (100) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle_ready_dut%0d", k), 64'(pr[k]), 64'h1);
      chk($sformatf("idle_digest_ready_dut%0d", k), 64'(dr[k]), 64'h0);
      chk($sformatf("idle_err_dut%0d", k), 64'(er[k]), 64'h0);
      chk($sformatf("idle_digest_dut%0d", k), dgw(k), 64'h0);
    end

    // Single byte 'a', defaults.
    push_exp(0, "a");
    send_byte(0, 8'h61, 1'b1);
    chk("ready_low_after_accept", 64'(pr[0]), 64'h0);
    wait_dr(0, n);
    chk("latency_single_a", 64'(n), 64'd32);
    chk("err_single_a", 64'(er[0]), 64'h0);
    do_ack(0);

    // Invalid byte in the middle, charset checked.
    push_exp(0, "a b");
    send_byte(0, 8'h61, 1'b0);
    wait_pr(0, n);
    chk("ready_low_cycles", 64'(n), 64'd32);
    chk("err_before_space", 64'(er[0]), 64'h0);
    send_byte(0, 8'h20, 1'b0);
    chk("err_after_space", 64'(er[0]), 64'h1);
    chk("ready_after_invalid", 64'(pr[0]), 64'h1);
    send_byte(0, 8'h62, 1'b1);
    wait_dr(0, n);
    chk("latency_after_invalid", 64'(n), 64'd32);
    do_ack(0);

    // Same stimulus, charset unchecked.
    push_exp(1, "a b");
    send_str(1, "a b");
    chk("err_unchecked", 64'(er[1]), 64'h0);
    wait_dr(1, n);
    chk("latency_unchecked_last", 64'(n), 64'd32);
    do_ack(1);

    // Repeatability with ack coinciding with the next valid.
    push_exp(0, "abc");
    send_str(0, "abc");
    wait_dr(0, n);
    repeat (3) @(posedge clk);
    #1;
    push_exp(0, "abc");
    ack[0] = 1'b1;
    fork
      begin
        @(posedge clk); #1;
        ack[0] = 1'b0;
      end
    join_none
    send_str(0, "abc");
    wait_dr(0, n);
    chk("latency_repeat_abc", 64'(n), 64'd32);
    do_ack(0);

    // Invalid last byte: digest appears right after acceptance.
    push_exp(0, " ");
    send_byte(0, 8'h20, 1'b1);
    chk("invalid_last_digest_ready", 64'(dr[0]), 64'h1);
    chk("invalid_last_err", 64'(er[0]), 64'h1);
    do_ack(0);

    // Reset while a digest is presented.
    push_exp(0, "q");
    send_byte(0, 8'h71, 1'b1);
    wait_dr(0, n);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero(0, "reset_in_done");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during round 10.
    send_byte(0, 8'h61, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero(0, "reset_in_round");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_abort", 64'(pr[0]), 64'h1);
    push_exp(0, "a");
    send_byte(0, 8'h61, 1'b1);
    wait_dr(0, n);
    chk("latency_after_abort", 64'(n), 64'd32);
    do_ack(0);

    // Smallest configuration: 3 bytes, one round.
    push_exp(2, "Z");
    send_byte(2, 8'h5A, 1'b1);
    wait_dr(2, n);
    chk("latency_small_Z", 64'(n), 64'd1);
    do_ack(2);
    push_exp(2, "YZ");
    send_byte(2, 8'h59, 1'b0);
    wait_pr(2, n);
    chk("ready_low_small", 64'(n), 64'd1);
    send_byte(2, 8'h5A, 1'b1);
    wait_dr(2, n);
    chk("latency_small_YZ", 64'(n), 64'd1);
    do_ack(2);

    // Every expected digest must have been presented.
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("pending_expected_dut%0d", k), 64'(qsize(k)), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
